// File: rtl/bus_ram_pkg.sv
// bus_ram shared types: MMIO map, FSM states, region decode.
// Optional timer feature is selected by BUS_RAM_TIMER_EN.
package bus_ram_pkg;

    localparam logic [31:0] ADDR_TXDATA   = 32'h8000_0000;
    localparam logic [31:0] ADDR_STATUS   = 32'h8000_0004;
    localparam logic [31:0] ADDR_TIMER_LO = 32'h8000_0008;
    localparam logic [31:0] ADDR_TIMER_HI = 32'h8000_000C;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [2:0] {
        RAM,
        UART_DATA,
        UART_STAT,
        TIMER,
        UNMAPPED
    } region_e;

    // Word address (byte address bits [31:2]) to target region.
    function automatic region_e decode_region(
        input logic [29:0] waddr,
        input int unsigned ram_words
    );
        region_e r;
        r = UNMAPPED;
        if (!waddr[29]) begin
            if ({2'b00, waddr} < ram_words) begin
                r = RAM;
            end
        end else if ({waddr, 2'b00} == ADDR_TXDATA) begin
            r = UART_DATA;
        end else if ({waddr, 2'b00} == ADDR_STATUS) begin
            r = UART_STAT;
        end else if ({waddr, 2'b00} == ADDR_TIMER_LO ||
                     {waddr, 2'b00} == ADDR_TIMER_HI) begin
            r = TIMER;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_ram_if.sv
// bus_ram_if: unified mem_* request/response bus.
// master drives requests, slave answers with a ready pulse.
interface bus_ram_if;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/bus_ram_uart_tx.sv
// bus_ram_uart_tx: 8N1 serializer, one byte per load.
// tx idles high; busy covers all ten bit periods.
module bus_ram_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       busy
);

    localparam int DW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

    logic [DW-1:0] div_q;
    logic [3:0]    bit_q;
    logic [8:0]    sh_q;

    // Start bit on load, then shift data LSB first, then stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx    <= 1'b1;
            busy  <= 1'b0;
            div_q <= '0;
            bit_q <= '0;
            sh_q  <= '1;
        end else if (load && !busy) begin
            tx    <= 1'b0;
            busy  <= 1'b1;
            div_q <= '0;
            bit_q <= '0;
            sh_q  <= {1'b1, tx_byte};
        end else if (busy) begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                if (bit_q == 4'd9) begin
                    busy <= 1'b0;
                    tx   <= 1'b1;
                end else begin
                    tx    <= sh_q[0];
                    sh_q  <= {1'b1, sh_q[8:1]};
                    bit_q <= bit_q + 4'd1;
                end
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

endmodule

// File: rtl/bus_ram.sv
// bus_ram: on-chip RAM plus UART/timer MMIO behind the mem_* bus.
// Define BUS_RAM_TIMER_EN to enable the 64-bit cycle timer.
module bus_ram
    import bus_ram_pkg::*;
#(
    parameter int RAM_WORDS    = 4096,
    parameter int WAIT_STATES  = 0,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic     clk,
    input  logic     rst,
    bus_ram_if.slave bus,
    output logic     uart_tx,
    output logic     bus_err
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam logic [15:0] WS_LOAD =
        (WAIT_STATES > 0) ? 16'(WAIT_STATES - 1) : 16'd0;

    state_e state_q, state_d;

    logic [29:0] a_q;
    logic [31:0] wd_q;
    logic [3:0]  ws_q;
    logic [15:0] cnt_q;

    logic [29:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wstrb;
    region_e     region;
    logic [AW-1:0] idx;

    logic        is_wr;
    logic        tx_wr;
    logic        tx_busy;
    logic        stall;
    logic        fire;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_val;

    logic [31:0] ram [RAM_WORDS];

`ifdef BUS_RAM_TIMER_EN
    logic [63:0] timer_q;
    logic [31:0] hi_q;
`endif

    // Live bus fields while idle, latched copy once accepted.
    always_comb begin
        c_addr  = a_q;
        c_wdata = wd_q;
        c_wstrb = ws_q;
        if (state_q == IDLE) begin
            c_addr  = bus.mem_addr[31:2];
            c_wdata = bus.mem_wdata;
            c_wstrb = bus.mem_wstrb;
        end
        region = decode_region(c_addr, RAM_WORDS);
        idx    = c_addr[AW-1:0];
        is_wr  = |c_wstrb;
        tx_wr  = (region == UART_DATA) && c_wstrb[0];
        stall  = tx_wr && tx_busy;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; fire marks the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    if (WAIT_STATES > 0 || stall) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        fire    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 16'd0 && !stall) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request and run the wait-state countdown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            wd_q  <= '0;
            ws_q  <= '0;
            cnt_q <= '0;
        end else if (state_q == IDLE && bus.mem_valid) begin
            a_q   <= bus.mem_addr[31:2];
            wd_q  <= bus.mem_wdata;
            ws_q  <= bus.mem_wstrb;
            cnt_q <= WS_LOAD;
        end else if (state_q == WAIT && cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    // Read mux; writes and unmapped reads return zero.
    always_comb begin
        rd_val = '0;
        if (!is_wr) begin
            unique case (region)
                RAM:       rd_val = ram[idx];
                UART_STAT: rd_val = {31'd0, tx_busy};
`ifdef BUS_RAM_TIMER_EN
                TIMER:     rd_val = c_addr[0] ? hi_q : timer_q[31:0];
`endif
                default:   rd_val = '0;
            endcase
        end
    end

    // Registered response and sticky unmapped-access flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            bus_err <= 1'b0;
        end else begin
            ready_q <= fire;
            if (fire) begin
                rdata_q <= rd_val;
                if (region == UNMAPPED) begin
                    bus_err <= 1'b1;
                end
            end
        end
    end

    // Byte-lane RAM write; contents are never reset.
    always_ff @(posedge clk) begin
        if (fire && region == RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wstrb[i]) begin
                    ram[idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef BUS_RAM_TIMER_EN
    // Free-running cycle timer; LO read snapshots HI.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= '0;
            hi_q    <= '0;
        end else begin
            timer_q <= timer_q + 64'd1;
            if (fire && region == TIMER && !is_wr && !c_addr[0]) begin
                hi_q <= timer_q[63:32];
            end
        end
    end
`endif

    bus_ram_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .load    (fire && tx_wr),
        .tx_byte (c_wdata[7:0]),
        .tx      (uart_tx),
        .busy    (tx_busy)
    );

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

endmodule
